// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle for uart_rx; slave = receiver, master = line driver and byte consumer.
// Each output is registered in the receiver. There is no backpressure: each new byte overwrites o_RX_Byte.
interface uart_rx_if;
   logic       i_RX_Serial;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_RX_Active;
   logic       o_RX_Frame_Err;

   modport master (
      output i_RX_Serial,
      input  o_RX_DV,
      input  o_RX_Byte,
      input  o_RX_Active,
      input  o_RX_Frame_Err
   );

   modport slave (
      input  i_RX_Serial,
      output o_RX_DV,
      output o_RX_Byte,
      output o_RX_Active,
      output o_RX_Frame_Err
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop synchronizer. The DV/Err pulse comes one cycle after the mid-stop sample; there is no backpressure.
// Optional UART_RX_MAJORITY_VOTE_EN: each bit sample is a 2-of-3 vote around the sample point.
module uart_rx #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic      i_Clock,
   input  logic      i_Rst_L,
   uart_rx_if.slave  rx_if
);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] RX_START_BIT = 2'd1;
   localparam logic [1:0] RX_DATA_BITS = 2'd2;
   localparam logic [1:0] RX_STOP_BIT  = 2'd3;

   localparam logic [13:0] MID_CNT  = 14'((CLKS_PER_BIT - 1) / 2);
   localparam logic [13:0] LAST_CNT = 14'(CLKS_PER_BIT - 1);

   logic [1:0]  state;
   logic [13:0] clk_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;
   logic [7:0]  rx_byte;
   logic        rx_dv;
   logic        rx_active;
   logic        rx_err;
   logic        sync1;
   logic        sync2;
   logic        sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
   // sync1 already holds the value sync2 takes next cycle, so the vote spans sample point -1..+1 without shifting decision timing
   logic sync3;

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         sync3 <= 1'b1;
      end else begin
         sync3 <= sync2;
      end
   end

   assign sample = (sync1 & sync2) | (sync1 & sync3) | (sync2 & sync3);
`else
   assign sample = sync2;
`endif

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         state     <= IDLE;
         clk_cnt   <= 14'd0;
         bit_idx   <= 3'd0;
         shift_reg <= 8'h00;
         rx_byte   <= 8'h00;
         rx_dv     <= 1'b0;
         rx_active <= 1'b0;
         rx_err    <= 1'b0;
      end else begin
         sync1  <= rx_if.i_RX_Serial;
         sync2  <= sync1;
         rx_dv  <= 1'b0;
         rx_err <= 1'b0;

         case (state)
            IDLE: begin
               clk_cnt <= 14'd0;
               bit_idx <= 3'd0;
               if (!sync2) begin
                  state     <= RX_START_BIT;
                  rx_active <= 1'b1;
               end
            end

            RX_START_BIT: begin
               if (clk_cnt == MID_CNT) begin
                  clk_cnt <= 14'd0;
                  if (!sample) begin
                     state <= RX_DATA_BITS;
                  end else begin
                     state     <= IDLE;
                     rx_active <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 14'd1;
               end
            end

            RX_DATA_BITS: begin
               if (clk_cnt == LAST_CNT) begin
                  clk_cnt            <= 14'd0;
                  shift_reg[bit_idx] <= sample;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= 3'd0;
                     state   <= RX_STOP_BIT;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 14'd1;
               end
            end

            RX_STOP_BIT: begin
               // Leave mid-stop-bit so a start edge right after the stop bit is still caught
               if (clk_cnt == LAST_CNT) begin
                  clk_cnt   <= 14'd0;
                  state     <= IDLE;
                  rx_active <= 1'b0;
                  if (sample) begin
                     rx_byte <= shift_reg;
                     rx_dv   <= 1'b1;
                  end else begin
                     rx_err  <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 14'd1;
               end
            end

            default: begin
               state     <= IDLE;
               clk_cnt   <= 14'd0;
               bit_idx   <= 3'd0;
               rx_active <= 1'b0;
            end
         endcase
      end
   end

   assign rx_if.o_RX_DV        = rx_dv;
   assign rx_if.o_RX_Byte      = rx_byte;
   assign rx_if.o_RX_Active    = rx_active;
   assign rx_if.o_RX_Frame_Err = rx_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: a table of frames plus hand-written corner sequences.
module tb_uart_rx;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_rx_if u_if();

   uart_rx #(.CLKS_PER_BIT(16)) dut (
      .i_Clock (clk),
      .i_Rst_L (rst_n),
      .rx_if   (u_if)
   );

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_dv;
      int         exp_err;
      logic [7:0] exp_byte;
      int         exp_act;
   } vec_t;

   vec_t vecs[5];

   int total = 0;
   int bad   = 0;

   int         dv_cnt   = 0;
   int         err_cnt  = 0;
   int         act_cnt  = 0;
   int         both_hi  = 0;
   logic [7:0] dv_log[64];

   always @(negedge clk) begin
      if (u_if.o_RX_DV) begin
         dv_log[dv_cnt % 64] = u_if.o_RX_Byte;
         dv_cnt++;
      end
      if (u_if.o_RX_Frame_Err) err_cnt++;
      if (u_if.o_RX_Active) act_cnt++;
      if (u_if.o_RX_DV && u_if.o_RX_Frame_Err) both_hi++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v);
      @(negedge clk);
      u_if.i_RX_Serial = v;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1);
   endtask

   // 160 line cycles: start, 8 data LSB first, stop; glitch_c inverts one cycle
   task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_c);
      logic v;
      for (int c = 0; c < 160; c++) begin
         if (c < 16)       v = 1'b0;
         else if (c < 144) v = d[(c - 16) / 16];
         else              v = stop;
         if (c == glitch_c) v = ~v;
         drive(v);
      end
   endtask

   initial begin
      int d0, e0, a0;
      logic [7:0] exp_b;

      vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5, 152};
      vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5, 160};
      vecs[2] = '{8'h55, 1'b1, 1, 0, 8'h55, 152};
      vecs[3] = '{8'hC3, 1'b0, 0, 1, 8'h55, 160};
      vecs[4] = '{8'h0F, 1'b1, 1, 0, 8'h0F, 152};

      rst_n = 1'b0;
      u_if.i_RX_Serial = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_byte", u_if.o_RX_Byte, 8'h00);
      check("reset_dv", u_if.o_RX_DV, 1'b0);
      check("reset_active", u_if.o_RX_Active, 1'b0);
      check("reset_err", u_if.o_RX_Frame_Err, 1'b0);
      rst_n = 1'b1;
      idle(10);

      for (int i = 0; i < 5; i++) begin
         d0 = dv_cnt; e0 = err_cnt; a0 = act_cnt;
         send_frame(vecs[i].data, vecs[i].stop, -1);
         idle(40);
         check($sformatf("vec%0d_dv", i), dv_cnt - d0, vecs[i].exp_dv);
         check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
         check($sformatf("vec%0d_byte", i), u_if.o_RX_Byte, vecs[i].exp_byte);
         check($sformatf("vec%0d_active", i), act_cnt - a0, vecs[i].exp_act);
      end

      // back-to-back frames, stop bit exactly one bit long
      d0 = dv_cnt; e0 = err_cnt;
      send_frame(8'h00, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      idle(40);
      check("b2b_dv", dv_cnt - d0, 2);
      check("b2b_err", err_cnt - e0, 0);
      check("b2b_byte0", dv_log[d0 % 64], 8'h00);
      check("b2b_byte1", dv_log[(d0 + 1) % 64], 8'hFF);

      // framing error keeps previous byte
      d0 = dv_cnt; e0 = err_cnt;
      send_frame(8'h3C, 1'b0, -1);
      idle(40);
      check("ferr_dv", dv_cnt - d0, 0);
      check("ferr_err", err_cnt - e0, 1);
      check("ferr_byte", u_if.o_RX_Byte, 8'hFF);

      // short low glitch is rejected at the start-bit midpoint
      d0 = dv_cnt; e0 = err_cnt; a0 = act_cnt;
      repeat (3) drive(1'b0);
      idle(30);
      check("glitch_dv", dv_cnt - d0, 0);
      check("glitch_err", err_cnt - e0, 0);
      check("glitch_active", act_cnt - a0, 8);

      // reset during data bit 4 of 0x5A
      d0 = dv_cnt; e0 = err_cnt;
      for (int c = 0; c < 88; c++) begin
         logic [7:0] b;
         b = 8'h5A;
         drive(c < 16 ? 1'b0 : b[(c - 16) / 16]);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_byte", u_if.o_RX_Byte, 8'h00);
      check("midrst_active", u_if.o_RX_Active, 1'b0);
      check("midrst_dv", u_if.o_RX_DV, 1'b0);
      check("midrst_err", u_if.o_RX_Frame_Err, 1'b0);
      rst_n = 1'b1;
      u_if.i_RX_Serial = 1'b1;
      idle(200);
      check("midrst_no_pulse", (dv_cnt - d0) + (err_cnt - e0), 0);
      d0 = dv_cnt;
      send_frame(8'h81, 1'b1, -1);
      idle(40);
      check("after_rst_dv", dv_cnt - d0, 1);
      check("after_rst_byte", u_if.o_RX_Byte, 8'h81);

      // one-cycle high glitch exactly on the bit-3 sample of 0x00
`ifdef UART_RX_MAJORITY_VOTE_EN
      exp_b = 8'h00;
`else
      exp_b = 8'h08;
`endif
      d0 = dv_cnt;
      send_frame(8'h00, 1'b1, 72);
      idle(40);
      check("vote_dv", dv_cnt - d0, 1);
      check("vote_byte", u_if.o_RX_Byte, exp_b);

      check("dv_err_overlap", both_hi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
